// File: rtl/hvsync_generator.sv
// VGA 640x480@60 timing generator: free-running X/Y counters with registered
// sync and display-enable outputs that line up with the X/Y presented.
module hvsync_generator #(
  parameter int   H_VISIBLE    = 640,
  parameter int   H_FRONT      = 16,
  parameter int   H_SYNC       = 96,
  parameter int   H_BACK       = 48,
  parameter int   V_VISIBLE    = 480,
  parameter int   V_FRONT      = 10,
  parameter int   V_SYNC       = 2,
  parameter int   V_BACK       = 33,
  parameter logic HSYNC_ACTIVE = 1'b0,
  parameter logic VSYNC_ACTIVE = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  output logic       o_vga_h_sync,
  output logic       o_vga_v_sync,
  output logic [9:0] o_HCounterX,
  output logic [9:0] o_HCounterY,
  output logic       o_inDisplayArea
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       de_q, de_d;

  // Flags are derived from the next counter values so that after the edge the
  // registered flags describe the registered X/Y in the same cycle.
  always_comb begin
    x_d = x_q + 10'd1;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      if (y_q == V_LAST) begin
        y_d = '0;
      end else begin
        y_d = y_q + 10'd1;
      end
    end
    de_d = (x_d < H_VIS) && (y_d < V_VIS);
    hs_d = ((x_d >= HS_START) && (x_d < HS_END)) ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
    vs_d = ((y_d >= VS_START) && (y_d < VS_END)) ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      x_q  <= '0;
      y_q  <= '0;
      hs_q <= ~HSYNC_ACTIVE;
      vs_q <= ~VSYNC_ACTIVE;
      de_q <= 1'b0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
    end
  end

  assign o_HCounterX     = x_q;
  assign o_HCounterY     = y_q;
  assign o_vga_h_sync    = hs_q;
  assign o_vga_v_sync    = vs_q;
  assign o_inDisplayArea = de_q;

endmodule

// File: tb/tb_hvsync_generator.sv
// Bench for hvsync_generator: a full-size instance plus one with a shortened
// vertical frame (11 lines, vsync on lines 6..7) so whole frames fit in a short run.
module tb_hvsync_generator;

  logic       clk;
  logic       rst_n;
  logic       hs0, vs0, de0, hs1, vs1, de1;
  logic [9:0] x0, y0, x1, y1;

  int checks = 0;
  int errors = 0;

  hvsync_generator dut0 (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .o_vga_h_sync    (hs0),
    .o_vga_v_sync    (vs0),
    .o_HCounterX     (x0),
    .o_HCounterY     (y0),
    .o_inDisplayArea (de0)
  );

  hvsync_generator #(
    .V_VISIBLE (4),
    .V_FRONT   (2),
    .V_SYNC    (2),
    .V_BACK    (3)
  ) dut1 (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .o_vga_h_sync    (hs1),
    .o_vga_v_sync    (vs1),
    .o_HCounterX     (x1),
    .o_HCounterY     (y1),
    .o_inDisplayArea (de1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #20 clk = ~clk;

  typedef struct {
    int n;
    bit sel;
    int x;
    int y;
    bit hs;
    bit vs;
    bit de;
  } vec_t;

  localparam int NT = 21;
  vec_t tbl [NT];

  // reference model state
  int mx, my0, my1, n_edge;
  int sweep_bad;
  bit prev_hs0, prev_vs1;
  int hs_last_fall, hs_prev_fall;
  int vs_last_fall, vs_spacing;
  int de_cnt, frame_de;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mx = 0; my0 = 0; my1 = 0; n_edge = 0;
    prev_hs0 = 1'b1; prev_vs1 = 1'b1;
  endtask

  // advance one clock, update the model, compare every output at the negedge
  task automatic step();
    bit e_hs, e_de0, e_vs0, e_de1, e_vs1;
    @(posedge clk);
    @(negedge clk);
    n_edge++;
    if (mx == 799) begin
      mx  = 0;
      my0 = (my0 == 524) ? 0 : my0 + 1;
      my1 = (my1 == 10) ? 0 : my1 + 1;
    end else begin
      mx++;
    end
    e_hs  = !(mx >= 656 && mx <= 751);
    e_de0 = (mx < 640) && (my0 < 480);
    e_vs0 = !(my0 >= 490 && my0 <= 491);
    e_de1 = (mx < 640) && (my1 < 4);
    e_vs1 = !(my1 >= 6 && my1 <= 7);
    if (int'(x0) != mx || int'(y0) != my0 || hs0 !== e_hs || vs0 !== e_vs0 || de0 !== e_de0)
      sweep_bad++;
    if (int'(x1) != mx || int'(y1) != my1 || hs1 !== e_hs || vs1 !== e_vs1 || de1 !== e_de1)
      sweep_bad++;
    if (prev_hs0 && !hs0) begin
      hs_prev_fall = hs_last_fall;
      hs_last_fall = n_edge;
    end
    if (de1) de_cnt++;
    if (prev_vs1 && !vs1) begin
      if (vs_last_fall >= 0) begin
        vs_spacing = n_edge - vs_last_fall;
        frame_de   = de_cnt;
      end
      vs_last_fall = n_edge;
      de_cnt = 0;
    end
    prev_hs0 = hs0;
    prev_vs1 = vs1;
  endtask

  task automatic chk_vec(input int i);
    if (tbl[i].sel == 1'b0) begin
      chk($sformatf("vec%0d_x", i), int'(x0), tbl[i].x);
      chk($sformatf("vec%0d_y", i), int'(y0), tbl[i].y);
      chk($sformatf("vec%0d_hs", i), int'(hs0), int'(tbl[i].hs));
      chk($sformatf("vec%0d_vs", i), int'(vs0), int'(tbl[i].vs));
      chk($sformatf("vec%0d_de", i), int'(de0), int'(tbl[i].de));
    end else begin
      chk($sformatf("vec%0d_x", i), int'(x1), tbl[i].x);
      chk($sformatf("vec%0d_y", i), int'(y1), tbl[i].y);
      chk($sformatf("vec%0d_hs", i), int'(hs1), int'(tbl[i].hs));
      chk($sformatf("vec%0d_vs", i), int'(vs1), int'(tbl[i].vs));
      chk($sformatf("vec%0d_de", i), int'(de1), int'(tbl[i].de));
    end
  endtask

  initial begin
    int idx;
    int found;
    // {edges since release, instance, x, y, hsync, vsync, de}
    tbl[0]  = '{1,    1'b0, 1,   0,  1'b1, 1'b1, 1'b1};
    tbl[1]  = '{639,  1'b0, 639, 0,  1'b1, 1'b1, 1'b1};
    tbl[2]  = '{640,  1'b0, 640, 0,  1'b1, 1'b1, 1'b0};
    tbl[3]  = '{655,  1'b0, 655, 0,  1'b1, 1'b1, 1'b0};
    tbl[4]  = '{656,  1'b0, 656, 0,  1'b0, 1'b1, 1'b0};
    tbl[5]  = '{751,  1'b0, 751, 0,  1'b0, 1'b1, 1'b0};
    tbl[6]  = '{752,  1'b0, 752, 0,  1'b1, 1'b1, 1'b0};
    tbl[7]  = '{799,  1'b0, 799, 0,  1'b1, 1'b1, 1'b0};
    tbl[8]  = '{800,  1'b0, 0,   1,  1'b1, 1'b1, 1'b1};
    tbl[9]  = '{801,  1'b0, 1,   1,  1'b1, 1'b1, 1'b1};
    tbl[10] = '{3039, 1'b1, 639, 3,  1'b1, 1'b1, 1'b1};
    tbl[11] = '{3199, 1'b1, 799, 3,  1'b1, 1'b1, 1'b0};
    tbl[12] = '{3200, 1'b1, 0,   4,  1'b1, 1'b1, 1'b0};
    tbl[13] = '{4799, 1'b1, 799, 5,  1'b1, 1'b1, 1'b0};
    tbl[14] = '{4800, 1'b1, 0,   6,  1'b1, 1'b0, 1'b0};
    tbl[15] = '{5456, 1'b1, 656, 6,  1'b0, 1'b0, 1'b0};
    tbl[16] = '{6399, 1'b1, 799, 7,  1'b1, 1'b0, 1'b0};
    tbl[17] = '{6400, 1'b1, 0,   8,  1'b1, 1'b1, 1'b0};
    tbl[18] = '{8799, 1'b1, 799, 10, 1'b1, 1'b1, 1'b0};
    tbl[19] = '{8800, 1'b1, 0,   0,  1'b1, 1'b1, 1'b1};
    tbl[20] = '{8800, 1'b0, 0,   11, 1'b1, 1'b1, 1'b1};

    sweep_bad = 0;
    hs_last_fall = -1; hs_prev_fall = -1;
    vs_last_fall = -1; vs_spacing = 0;
    de_cnt = 0; frame_de = 0;

    // reset values while held
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_x0", int'(x0), 0);
    chk("rst_y0", int'(y0), 0);
    chk("rst_hs0", int'(hs0), 1);
    chk("rst_vs0", int'(vs0), 1);
    chk("rst_de0", int'(de0), 0);
    chk("rst_y1", int'(y1), 0);
    chk("rst_vs1", int'(vs1), 1);
    rst_n = 1'b1;
    model_reset();

    // line and frame timing over two short frames
    idx = 0;
    for (int k = 0; k < 17600; k++) begin
      step();
      while (idx < NT && tbl[idx].n == n_edge) begin
        chk_vec(idx);
        idx++;
      end
    end
    chk("table_reached", idx, NT);
    chk("sweep_mismatch", sweep_bad, 0);
    chk("hsync_period", hs_last_fall - hs_prev_fall, 800);
    chk("vsync_period", vs_spacing, 8800);
    chk("frame_de_count", frame_de, 2560);
    sweep_bad = 0;

    // asynchronous reset mid-line
    for (int k = 0; k < 800 && mx != 300; k++) step();
    chk("pre_reset_x0", int'(x0), 300);
    chk("pre_reset_de0", int'(de0), 1);
    #5 rst_n = 1'b0;
    #1;
    chk("async_x0", int'(x0), 0);
    chk("async_y0", int'(y0), 0);
    chk("async_hs0", int'(hs0), 1);
    chk("async_vs0", int'(vs0), 1);
    chk("async_de0", int'(de0), 0);
    @(negedge clk);
    chk("held_x0", int'(x0), 0);
    rst_n = 1'b1;
    model_reset();
    step();
    chk("first_edge_x0", int'(x0), 1);
    chk("first_edge_y0", int'(y0), 0);
    chk("first_edge_de0", int'(de0), 1);
    chk("first_edge_hs0", int'(hs0), 1);

    // asynchronous reset during vsync, then time to the next vsync
    for (int k = 0; k < 6000 && !(mx == 700 && my1 == 6); k++) step();
    chk("pre_reset_vs1", int'(vs1), 0);
    chk("pre_reset_hs1", int'(hs1), 0);
    #5 rst_n = 1'b0;
    #1;
    chk("async_vs1", int'(vs1), 1);
    chk("async_hs1", int'(hs1), 1);
    chk("async_x1", int'(x1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    found = 10000;
    for (int k = 0; k < 10000; k++) begin
      step();
      if (vs1 == 1'b0) begin
        found = n_edge;
        break;
      end
    end
    chk("vsync_after_reset", found, 4800);
    chk("sweep_mismatch_late", sweep_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hvsync_generator.md
Name: hvsync_generator

Overview:
- Free-running VGA timing generator for 640x480 at 60 Hz, using a 25.175 MHz pixel clock.
- Produces the horizontal and vertical sync pulses, the current pixel X/Y position and a display-area (data-enable) flag.
- Instantiated by the VGA output stage, which uses X/Y to address the frame RAM and uses the flag to force black during blanking.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_ACTIVE, 0, level driven on o_vga_h_sync during the sync pulse (0 = negative polarity)
- VSYNC_ACTIVE, 0, level driven on o_vga_v_sync during the sync pulse

Ports:
- i_clk  input  1  pixel clock, rising-edge
- i_reset_n  input  1  reset, asynchronous assert, active-low
- o_vga_h_sync  output  1  horizontal sync
- o_vga_v_sync  output  1  vertical sync
- o_HCounterX  output  10  current pixel column, 0..H_TOTAL-1
- o_HCounterY  output  10  current line, 0..V_TOTAL-1
- o_inDisplayArea  output  1  high when X < H_VISIBLE and Y < V_VISIBLE

Behaviour:
- Interface decision: one clock (i_clk); reset i_reset_n is asynchronous and active-low.
- Derived totals:
  - H_TOTAL = sum of the four H parameters = 800.
  - V_TOTAL = sum of the four V parameters = 525.
- Reset (i_reset_n = 0), applied immediately and independent of the clock:
  - X = 0, Y = 0.
  - o_vga_h_sync = ~HSYNC_ACTIVE (1); o_vga_v_sync = ~VSYNC_ACTIVE (1).
  - o_inDisplayArea = 0.
- X counter: increments by 1 on every rising edge; at X = H_TOTAL-1 it wraps to 0.
- Y counter:
  - Increments only on the edge where X wraps.
  - At Y = V_TOTAL-1 with X wrapping, Y wraps to 0.
  - Otherwise Y holds.
- All outputs are registered. Flags and sync levels are computed from the next counter values, so in every cycle after the first post-reset edge, sync and display outputs describe exactly the X/Y currently presented (zero relative latency).
- o_inDisplayArea = (X < H_VISIBLE) && (Y < V_VISIBLE), i.e. X 0..639 and Y 0..479.
- Horizontal sync: o_vga_h_sync = HSYNC_ACTIVE when H_VISIBLE+H_FRONT <= X < H_VISIBLE+H_FRONT+H_SYNC, i.e. X 656..751 (96 clocks).
- Vertical sync: o_vga_v_sync = VSYNC_ACTIVE when V_VISIBLE+V_FRONT <= Y < V_VISIBLE+V_FRONT+V_SYNC, i.e. Y 490..491. It spans whole lines, 2 x 800 = 1600 clocks.
- Vertical sync is independent of X; both syncs may be active simultaneously.
- First edge after reset release:
  - X = 1, Y = 0, o_inDisplayArea = 1, both syncs inactive.
  - From then on the sequence is strictly periodic: line period 800 clocks, frame period 420000 clocks.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously). Counting restarts from 0 after release, with no partial-state carry-over.
- Counter widths:
  - 10 bits is sufficient (max 799 / 524).
  - Comparisons are unsigned.
  - Counters never reach values at or above H_TOTAL / V_TOTAL.

Test Plan:
1. Async reset: assert i_reset_n=0 between clock edges mid-line (X≈300, Y≈100) -> X=0, Y=0, hsync=1, vsync=1, de=0 without waiting for an edge; release -> first edge gives X=1, Y=0, de=1.
2. Line timing: run one line from X=0 -> de=1 for X 0..639, de=0 for X 640..799; hsync=0 exactly for X 656..751 (96 clocks); X wraps 799->0 and Y increments by 1 on that edge.
3. Frame timing: run a full frame -> Y counts 0..524 then wraps to 0 when X wraps at Y=524; vsync=0 exactly for Y 490..491 (1600 consecutive clocks); de=0 for all Y >= 480.
4. Periodicity: measure hsync falling-edge spacing = 800 clocks; vsync falling-edge spacing = 420000 clocks; 480 lines x 640 = 307200 de-high clocks per frame.
5. Alignment: at every clock check de == (X<640 && Y<480) and hsync == !(656<=X<=751), using the same-cycle X/Y values; no off-by-one.
6. Reset mid-vsync: assert reset at Y=490, X=700 -> vsync returns to 1 immediately; after release, next vsync assertion occurs 490x800 clocks after the first post-reset edge.
